// File: rtl/div_sched_pkg.sv
// State encoding shared by the divider scheduler.
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/div_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above pointer, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      pointer,
    output logic [NUM_REQ-1:0] winner,
    output logic [PW-1:0]      winner_idx
);
    always_comb begin
        int            j;
        logic [PW-1:0] jj;
        logic          found;
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        j          = 0;
        jj         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(pointer) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = PW'(j);
            if (!found && req[jj]) begin
                found      = 1'b1;
                winner[jj] = 1'b1;
                winner_idx = jj;
            end
        end
    end
endmodule

// File: rtl/div_scheduler.sv
// Round-robin front end sharing one iterative divider among NUM_REQ clients.
// Define DIV_SCHED_ZERO_GUARD_EN to answer zero divisors locally in one cycle.
module div_scheduler
    import div_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BIT_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BIT_DEPTH-1:0] dividend,
    input  logic [NUM_REQ*BIT_DEPTH-1:0] divisor,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [BIT_DEPTH-1:0]         quotient_out,
    output logic [BIT_DEPTH-1:0]         remainder_out,
    output logic                         div0,
    output logic                         div_start,
    output logic [BIT_DEPTH-1:0]         div_dividend,
    output logic [BIT_DEPTH-1:0]         div_divisor,
    input  logic                         div_done,
    input  logic [BIT_DEPTH-1:0]         div_quotient,
    input  logic [BIT_DEPTH-1:0]         div_remainder
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                            state, state_n;
    logic [PW-1:0]                     ptr, ptr_n, owner, owner_n, next_ptr, win_idx;
    logic [NUM_REQ-1:0]                win_oh, grant_n, resp_n;
    logic [BIT_DEPTH-1:0]              quot_n, rem_n, dvd_n, dvs_n;
    logic                              start_n;
    logic [NUM_REQ-1:0][BIT_DEPTH-1:0] dvd_arr, dvs_arr;

`ifdef DIV_SCHED_ZERO_GUARD_EN
    logic zero_pend, zero_pend_n, div0_q, div0_n;
    assign div0 = div0_q;
`else
    assign div0 = 1'b0;
`endif

    assign dvd_arr  = dividend;
    assign dvs_arr  = divisor;
    assign next_ptr = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req),
        .pointer    (ptr),
        .winner     (win_oh),
        .winner_idx (win_idx)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        grant_n = grant;
        resp_n  = '0;
        quot_n  = quotient_out;
        rem_n   = remainder_out;
        start_n = div_start;
        dvd_n   = div_dividend;
        dvs_n   = div_divisor;
`ifdef DIV_SCHED_ZERO_GUARD_EN
        zero_pend_n = zero_pend;
        div0_n      = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Never start while the divider still reports a finished result.
                if (|req && !div_done) begin
                    grant_n = win_oh;
                    owner_n = win_idx;
                    dvd_n   = dvd_arr[win_idx];
                    dvs_n   = dvs_arr[win_idx];
                    state_n = RUN;
`ifdef DIV_SCHED_ZERO_GUARD_EN
                    if (dvs_arr[win_idx] == '0) zero_pend_n = 1'b1;
                    else                        start_n     = 1'b1;
`else
                    start_n = 1'b1;
`endif
                end
            end
            RUN: begin
`ifdef DIV_SCHED_ZERO_GUARD_EN
                if (zero_pend) begin
                    resp_n      = grant;
                    quot_n      = '1;
                    rem_n       = div_dividend;
                    div0_n      = 1'b1;
                    grant_n     = '0;
                    ptr_n       = next_ptr;
                    zero_pend_n = 1'b0;
                    state_n     = IDLE;
                end else
`endif
                if (div_done) begin
                    resp_n  = grant;
                    quot_n  = div_quotient;
                    rem_n   = div_remainder;
                    start_n = 1'b0;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (!div_done) begin
                    grant_n = '0;
                    ptr_n   = next_ptr;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            grant         <= '0;
            resp_valid    <= '0;
            quotient_out  <= '0;
            remainder_out <= '0;
            div_start     <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
`ifdef DIV_SCHED_ZERO_GUARD_EN
            zero_pend     <= 1'b0;
            div0_q        <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            owner         <= owner_n;
            grant         <= grant_n;
            resp_valid    <= resp_n;
            quotient_out  <= quot_n;
            remainder_out <= rem_n;
            div_start     <= start_n;
            div_dividend  <= dvd_n;
            div_divisor   <= dvs_n;
`ifdef DIV_SCHED_ZERO_GUARD_EN
            zero_pend     <= zero_pend_n;
            div0_q        <= div0_n;
`endif
        end
    end
endmodule

// File: tb/tb_div_scheduler.sv
// Randomized bench for div_scheduler with a divider model and a timeline-level reference.
module tb_div_scheduler;
    localparam int NR = 4;
    localparam int BD = 8;
`ifdef DIV_SCHED_ZERO_GUARD_EN
    localparam bit ZG = 1'b1;
`else
    localparam bit ZG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req;
    logic [NR*BD-1:0] dividend, divisor;
    logic [NR-1:0]    grant, resp_valid;
    logic [BD-1:0]    quotient_out, remainder_out, div_dividend, div_divisor;
    logic             div0, div_start, div_done;
    logic [BD-1:0]    div_quotient, div_remainder;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_scheduler #(.NUM_REQ(NR), .BIT_DEPTH(BD)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .dividend      (dividend),
        .divisor       (divisor),
        .grant         (grant),
        .resp_valid    (resp_valid),
        .quotient_out  (quotient_out),
        .remainder_out (remainder_out),
        .div0          (div0),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Divider: start seen -> BD iterations -> done held until start is low.
    logic          dv_busy;
    int            dv_cnt;
    logic [BD-1:0] dv_a, dv_b;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dv_busy <= 1'b0; dv_cnt <= 0; dv_a <= '0; dv_b <= '0;
            div_done <= 1'b0; div_quotient <= '0; div_remainder <= '0;
        end else if (dv_busy) begin
            dv_cnt <= dv_cnt + 1;
            if (dv_cnt == BD - 1) begin
                dv_busy       <= 1'b0;
                div_done      <= 1'b1;
                div_quotient  <= (dv_b == 0) ? '0 : dv_a / dv_b;
                div_remainder <= (dv_b == 0) ? dv_a : dv_a % dv_b;
            end
        end else if (div_done) begin
            if (!div_start) div_done <= 1'b0;
        end else if (div_start) begin
            dv_busy <= 1'b1; dv_cnt <= 0; dv_a <= div_dividend; dv_b <= div_divisor;
        end
    end

    // Reference: each operation is a fixed timeline k = edges since issue.
    function automatic int rr_pick(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
        return 0;
    endfunction

    function automatic int oh2idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    int            m_ptr = 0, m_win = 0, m_k = 0;
    bit            m_busy = 0, m_zero = 0;
    logic [BD-1:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;
    logic [NR-1:0] m_grant = '0, m_resp = '0;
    logic          m_start = 1'b0, m_div0 = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ptr = 0; m_busy = 0; m_zero = 0; m_k = 0;
            m_a = '0; m_b = '0; m_q = '0; m_r = '0;
            m_grant = '0; m_resp = '0; m_start = 1'b0; m_div0 = 1'b0;
        end else begin
            m_resp = '0;
            m_div0 = 1'b0;
            if (m_busy) begin
                m_k++;
                if (m_zero && m_k == 1) begin
                    m_resp = NR'(1) << m_win; m_q = '1; m_r = m_a; m_div0 = 1'b1;
                    m_busy = 0; m_ptr = (m_win + 1) % NR;
                end else if (!m_zero && m_k == BD + 2) begin
                    m_resp = NR'(1) << m_win;
                    m_q    = (m_b == 0) ? '0 : m_a / m_b;
                    m_r    = (m_b == 0) ? m_a : m_a % m_b;
                end else if (!m_zero && m_k == BD + 4) begin
                    m_busy = 0; m_ptr = (m_win + 1) % NR;
                end
            end else if (req != '0) begin
                m_win  = rr_pick(req, m_ptr);
                m_a    = dividend[m_win*BD +: BD];
                m_b    = divisor[m_win*BD +: BD];
                m_zero = ZG && (m_b == 0);
                m_busy = 1; m_k = 0;
            end
            m_grant = m_busy ? (NR'(1) << m_win) : '0;
            m_start = m_busy && !m_zero && (m_k <= BD + 1);
        end
    end

    logic start_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            chk("grant", grant, m_grant);
            chk("resp_valid", resp_valid, m_resp);
            chk("div_start", div_start, m_start);
            chk("div_dividend", div_dividend, m_a);
            chk("div_divisor", div_divisor, m_b);
            chk("quotient_out", quotient_out, m_q);
            chk("remainder_out", remainder_out, m_r);
            if (m_resp != '0) chk("div0", div0, m_div0);
            chk("start_rise_while_done", div_start && div_done && !start_prev, 0);
        end
        start_prev = div_start;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        dividend[i*BD +: BD] = BD'(a);
        divisor[i*BD +: BD]  = BD'(b);
    endtask

    task automatic wait_grant(output int idx, output int at);
        idx = -1; at = 0;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (grant != '0) begin idx = oh2idx(grant); at = cyc; return; end
        end
        timeout_fail("wait_grant");
    endtask

    task automatic wait_resp(input int i, output int k);
        k = 0;
        for (int n = 0; n < 64; n++) begin
            tick(); k++;
            if (resp_valid[i]) return;
        end
        k = -1;
        timeout_fail("wait_resp");
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 64; n++) begin
            tick();
            if (grant == '0) return;
        end
        timeout_fail("wait_idle");
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset = 1'b1; req = '0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_start", div_start, 0);
        chk("rst_resp", resp_valid, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
    endtask

    task automatic rand_op(input int i);
        set_op(i, $urandom_range(0, 255), ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 255));
    endtask

    int ca[4] = '{100, 77, 250, 13};
    int cb[4] = '{9, 5, 16, 13};
    int eq[4] = '{11, 15, 15, 1};
    int er[4] = '{1, 2, 10, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int idx, at, k, prev_at;
        logic [NR-1:0] seen;
        reset = 1'b1; req = '0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_grant", grant, 0);
        chk("reset_resp", resp_valid, 0);
        chk("reset_q", quotient_out, 0);
        chk("reset_r", remainder_out, 0);
        chk("reset_div0", div0, 0);
        chk("reset_start", div_start, 0);
        chk("reset_dvd", div_dividend, 0);
        chk("reset_dvs", div_divisor, 0);
        #2 reset = 1'b0;

        // Single request
        set_op(2, 200, 7); req = 4'b0100;
        wait_grant(idx, at);
        chk("single_grant", grant, 4'b0100);
        chk("single_start", div_start, 1);
        wait_resp(2, k);
        chk("single_latency", k, BD + 2);
        req = '0;
        chk("single_q", quotient_out, 28);
        chk("single_r", remainder_out, 4);
        chk("single_div0", div0, 0);
        wait_idle();

        // Zero divisor
        set_op(1, 55, 0); req = 4'b0010;
        wait_grant(idx, at);
        chk("zero_grant_idx", idx, 1);
`ifdef DIV_SCHED_ZERO_GUARD_EN
        chk("zero_no_start", div_start, 0);
        wait_resp(1, k);
        req = '0;
        chk("zero_latency", k, 1);
        chk("zero_q", quotient_out, 255);
        chk("zero_r", remainder_out, 55);
        chk("zero_div0", div0, 1);
        chk("zero_grant_clear", grant, 0);
        chk("zero_start_low", div_start, 0);
`else
        wait_resp(1, k);
        req = '0;
        chk("zero_latency", k, BD + 2);
        chk("zero_q", quotient_out, 0);
        chk("zero_r", remainder_out, 55);
        chk("zero_div0", div0, 0);
`endif
        wait_idle();

        // Contention with all requesters held
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, ca[i], cb[i]);
        req = '1;
        prev_at = 0;
        for (int n = 0; n < 5; n++) begin
            wait_grant(idx, at);
            chk("cont_order", idx, n % NR);
            if (n > 0) chk("cont_spacing", at - prev_at, BD + 5);
            prev_at = at;
            wait_resp(n % NR, k);
            chk("cont_q", quotient_out, eq[n % NR]);
            chk("cont_r", remainder_out, er[n % NR]);
            wait_idle();
        end
        req = '0;
        wait_idle();

        // Wrap: requester 0 follows requester 3
        do_reset();
        set_op(3, 90, 4); req = 4'b1000;
        wait_grant(idx, at);
        chk("wrap_first", idx, 3);
        set_op(0, 33, 3); req[0] = 1'b1;
        wait_resp(3, k);
        chk("wrap_q3", quotient_out, 22);
        chk("wrap_r3", remainder_out, 2);
        wait_idle();
        wait_grant(idx, at);
        chk("wrap_next", idx, 0);
        req = '0;
        wait_resp(0, k);
        chk("wrap_q0", quotient_out, 11);
        wait_idle();

        // Reset in the middle of a run
        set_op(2, 200, 7); req = 4'b0100;
        wait_grant(idx, at);
        repeat (5) tick();
        reset = 1'b1; req = '0;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_start", div_start, 0);
        chk("mid_rst_resp", resp_valid, 0);
        chk("mid_rst_q", quotient_out, 0);
        chk("mid_rst_r", remainder_out, 0);
        chk("mid_rst_dvd", div_dividend, 0);
        chk("mid_rst_dvs", div_divisor, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        seen = '0;
        for (int n = 0; n < 15; n++) begin tick(); seen |= resp_valid; end
        chk("mid_rst_no_resp", seen, 0);
        set_op(2, 200, 7); req = 4'b0100;
        wait_grant(idx, at);
        wait_resp(2, k);
        req = '0;
        chk("after_rst_latency", k, BD + 2);
        chk("after_rst_q", quotient_out, 28);
        chk("after_rst_r", remainder_out, 4);
        wait_idle();

        // Dropped request still completes
        do_reset();
        set_op(0, 99, 10); set_op(1, 60, 7); req = 4'b0011;
        wait_grant(idx, at);
        chk("drop_first", idx, 0);
        repeat (3) tick();
        req[0] = 1'b0;
        wait_resp(0, k);
        chk("drop_latency", k, BD + 2 - 3);
        chk("drop_q", quotient_out, 9);
        chk("drop_r", remainder_out, 9);
        wait_idle();
        wait_grant(idx, at);
        chk("drop_next", idx, 1);
        req = '0;
        wait_resp(1, k);
        chk("drop_q1", quotient_out, 8);
        chk("drop_r1", remainder_out, 4);
        wait_idle();

        // Random traffic against the reference
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin req[i] = 1'b1; rand_op(i); end
                end else if (resp_valid[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else rand_op(i);
                end else if (grant[i] && $urandom_range(0, 39) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
        req = '0;
        repeat (30) @(posedge clk);
        #1;
        chk("final_idle_grant", grant, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
